// File: rtl/fir_pkg.sv
// Shared types and helpers for the folded symmetric FIR sequencer.
// Provides the FSM state type, the default half-length and address helpers.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  localparam int N_TAPS_DEF = 16;
  localparam int N_HALF     = N_TAPS_DEF / 2;

  function automatic int n_half(input int n_taps);
    return n_taps / 2;
  endfunction

  // Reverse tap walks the mirrored half of the delay line.
  function automatic int rev_addr(input int k, input int nh);
    return nh - 1 - k;
  endfunction

endpackage

// File: rtl/fir_enable_pipe.sv
// Delays tap_active/first_tap by PIPE_LAT cycles to align MAC enables.
// Ports: clk, rst (async high), i_tap_active, i_first_tap -> o_mac_en, o_mac_clr.
module fir_enable_pipe #(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tap_active,
  input  logic i_first_tap,
  output logic o_mac_en,
  output logic o_mac_clr
);

  logic [PIPE_LAT-1:0] r_act;
  logic [PIPE_LAT-1:0] r_first;

  // Shift-left form keeps the PIPE_LAT=1 case free of empty slices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act   <= '0;
      r_first <= '0;
    end else begin
      r_act   <= (r_act << 1) | PIPE_LAT'(i_tap_active);
      r_first <= (r_first << 1) | PIPE_LAT'(i_first_tap);
    end
  end

  assign o_mac_en  = r_act[PIPE_LAT-1];
  assign o_mac_clr = r_first[PIPE_LAT-1];

endmodule

// File: rtl/fir_sequencer.sv
// Single-clock control FSM for the folded symmetric FIR datapath.
// Ports: in_valid/in_ready sample handshake; shift_en, addr_fwd, addr_rev,
// rom_addr, mac_clr, mac_en datapath controls; busy; out_valid/out_ready.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS     = 16,
  parameter int WIDTH_ADDR = 3,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  shift_en,
  output logic [WIDTH_ADDR-1:0] addr_fwd,
  output logic [WIDTH_ADDR-1:0] addr_rev,
  output logic [WIDTH_ADDR-1:0] rom_addr,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int NH = n_half(N_TAPS);
  // Counter serves both ACCUM (to NH-1) and DRAIN (to PIPE_LAT-1 <= 3).
  localparam int CW = (WIDTH_ADDR > 2) ? WIDTH_ADDR : 2;
  localparam logic [CW-1:0] K_LAST = CW'(NH - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PIPE_LAT - 1);

  if (N_TAPS < 4 || (N_TAPS % 2) != 0 ||
      $clog2(N_TAPS / 2) != WIDTH_ADDR ||
      PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_param
    $error("fir_sequencer: illegal parameters");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_k;
  logic [CW-1:0] w_k_nxt;
  logic          w_accum;
  logic          w_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_k_nxt     = '0;
        w_state_nxt = ACCUM;
      end
      ACCUM: begin
        if (r_k == K_LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = DRAIN;
        end else begin
          w_k_nxt = r_k + CW'(1);
        end
      end
      DRAIN: begin
        if (r_k == P_LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = DONE;
        end else begin
          w_k_nxt = r_k + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_k_nxt     = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accum = (r_state == ACCUM);
  assign w_first = w_accum && (r_k == '0);

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign shift_en  = (r_state == SHIFT);
  assign out_valid = (r_state == DONE);

  assign addr_fwd = w_accum ? r_k[WIDTH_ADDR-1:0] : '0;
  assign rom_addr = addr_fwd;
  assign addr_rev = w_accum ?
    WIDTH_ADDR'(rev_addr(int'(r_k), NH)) : '0;

  fir_enable_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .i_tap_active (w_accum),
    .i_first_tap  (w_first),
    .o_mac_en     (mac_en),
    .o_mac_clr    (mac_clr)
  );

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: default plus two corner-parameter instances.
// Cycle-level timing model and an out_valid completion scoreboard.
module tb_fir_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv   [3];
  logic ordy [3];
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [5:0] f0, f1, f2;
  wire [2:0] a0_fwd, a0_rev, a0_rom;
  wire [0:0] a1_fwd, a1_rev, a1_rom;
  wire [3:0] a2_fwd, a2_rev, a2_rom;

  fir_sequencer #(.N_TAPS(16), .WIDTH_ADDR(3), .PIPE_LAT(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(f0[5]),
    .shift_en(f0[3]), .addr_fwd(a0_fwd), .addr_rev(a0_rev),
    .rom_addr(a0_rom), .mac_clr(f0[1]), .mac_en(f0[2]),
    .busy(f0[4]), .out_valid(f0[0]), .out_ready(ordy[0]));

  fir_sequencer #(.N_TAPS(4), .WIDTH_ADDR(1), .PIPE_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(f1[5]),
    .shift_en(f1[3]), .addr_fwd(a1_fwd), .addr_rev(a1_rev),
    .rom_addr(a1_rom), .mac_clr(f1[1]), .mac_en(f1[2]),
    .busy(f1[4]), .out_valid(f1[0]), .out_ready(ordy[1]));

  fir_sequencer #(.N_TAPS(32), .WIDTH_ADDR(4), .PIPE_LAT(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(f2[5]),
    .shift_en(f2[3]), .addr_fwd(a2_fwd), .addr_rev(a2_rev),
    .rom_addr(a2_rom), .mac_clr(f2[1]), .mac_en(f2[2]),
    .busy(f2[4]), .out_valid(f2[0]), .out_ready(ordy[2]));

  wire [29:0] obs0 = {f0, 8'(a0_fwd), 8'(a0_rev), 8'(a0_rom)};
  wire [29:0] obs1 = {f1, 8'(a1_fwd), 8'(a1_rev), 8'(a1_rom)};
  wire [29:0] obs2 = {f2, 8'(a2_fwd), 8'(a2_rev), 8'(a2_rom)};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] get_obs(input int i);
    case (i)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  function automatic int nh_of(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int pl_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // Expected outputs, rel = cycles since the accepted handshake.
  function automatic logic [29:0] model(input int rel, input int nh,
                                        input int pl, input bit idle);
    logic [5:0] f;
    int a;
    int r;
    f = '0;
    a = 0;
    r = 0;
    if (idle) begin
      f[5] = 1'b1;
    end else begin
      f[4] = 1'b1;
      f[3] = (rel == 1);
      if (rel >= 2 && rel <= nh + 1) begin
        a = rel - 2;
        r = nh - 1 - a;
      end
      f[2] = (rel >= 2 + pl) && (rel <= nh + 1 + pl);
      f[1] = (rel == 2 + pl);
      f[0] = (rel >= nh + 2 + pl);
    end
    return {f, 8'(a), 8'(r), 8'(a)};
  endfunction

  int q0[$];
  int q1[$];
  int q2[$];

  task automatic sb_push(input int i, input int v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int i, output int v);
    v = -1;
    case (i)
      0:       if (q0.size() > 0) v = q0.pop_front();
      1:       if (q1.size() > 0) v = q1.pop_front();
      default: if (q2.size() > 0) v = q2.pop_front();
    endcase
  endtask

  bit act [3];
  int t0  [3];
  bit pov [3];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        act[i] = 1'b0;
        pov[i] = 1'b0;
      end
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        int rel;
        int nh;
        int pl;
        int ev;
        logic [29:0] o;
        rel = cyc - t0[i];
        nh  = nh_of(i);
        pl  = pl_of(i);
        o   = get_obs(i);
        chk($sformatf("outs%0d@%0d", i, cyc), 32'(o),
            32'(model(rel, nh, pl, !act[i])));
        if (o[24] && !pov[i]) begin
          sb_pop(i, ev);
          chk($sformatf("done_cyc%0d", i), cyc, ev);
        end
        pov[i] = o[24];
        if (!act[i] && iv[i]) begin
          act[i] = 1'b1;
          t0[i]  = cyc;
          sb_push(i, cyc + nh + 2 + pl);
        end else if (act[i] && rel >= nh + 2 + pl && ordy[i]) begin
          act[i] = 1'b0;
        end
      end
    end
  end

  task automatic pulse(input bit all3);
    @(posedge clk);
    #1;
    iv[0] = 1'b1;
    if (all3) begin
      iv[1] = 1'b1;
      iv[2] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
  endtask

  logic [29:0] idle_vec;

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    idle_vec = model(0, 8, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs0", 32'(obs0), 32'(idle_vec));
    chk("rst_outs1", 32'(obs1), 32'(idle_vec));
    chk("rst_outs2", 32'(obs2), 32'(idle_vec));
    #1 rst = 1'b0;

    repeat (20) @(posedge clk);

    pulse(1'b1);
    repeat (25) @(posedge clk);

    #1 iv[0] = 1'b1;
    repeat (13 * 3 + 1) @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (15) @(posedge clk);

    #1 ordy[0] = 1'b0;
    pulse(1'b0);
    repeat (24) @(posedge clk);
    #1 ordy[0] = 1'b1;
    repeat (3) @(posedge clk);

    pulse(1'b1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_outs0", 32'(obs0), 32'(idle_vec));
    chk("arst_outs1", 32'(obs1), 32'(idle_vec));
    chk("arst_outs2", 32'(obs2), 32'(idle_vec));
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);

    pulse(1'b1);
    repeat (30) @(posedge clk);

    chk("sb_left0", q0.size(), 0);
    chk("sb_left1", q1.size(), 0);
    chk("sb_left2", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Control unit for the folded symmetric FIR datapath: two tap shift registers, pre-adder, coefficient ROM and MAC.
- Replaces the divided-clock and free-running-counter timing with a single-clock FSM on clk.
- Accepts one input sample per valid/ready handshake and generates all datapath control signals for one output:
  - delay-line shift enable
  - forward/reverse tap addresses
  - ROM address
  - MAC clear/enable
- Holds the result until the consumer accepts it.

Parameters:
- N_TAPS, 16, total filter taps; must be even and >= 4; N_HALF = N_TAPS/2 folded products per sample.
- WIDTH_ADDR, 3, tap/ROM address width; must equal clog2(N_TAPS/2).
- PIPE_LAT, 2, cycles from address presentation to pre-adder/ROM data at the MAC input; legal range 1..4.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an input sample is present on the datapath input register.
- in_ready  out  1  sequencer can take a sample; high only in IDLE.
- shift_en  out  1  one-cycle pulse: load the sample and shift both tap registers by one.
- addr_fwd  out  WIDTH_ADDR  read address of the forward tap register.
- addr_rev  out  WIDTH_ADDR  read address of the reverse tap register.
- rom_addr  out  WIDTH_ADDR  coefficient ROM address.
- mac_clr  out  1  MAC accumulator loads its product instead of adding; coincides with the first mac_en.
- mac_en  out  1  MAC accumulates this cycle.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  MAC result is final and stable.
- out_ready  in  1  consumer takes the result.

Behaviour:
- All outputs are Moore outputs, decoded from state/counter registers. No combinational path runs from any input to any output, except that in_ready depends on state only.
- Reset (asynchronous, at any time, including mid-sequence):
  - state goes to IDLE; tap counter and enable pipe go to 0.
  - outputs: in_ready=1, busy=0, all other outputs 0.
  - Any partial accumulation is abandoned. The first sample after reset starts a clean sequence.
- States:
  - IDLE: in_ready=1. When in_valid=1, go to SHIFT; this cycle is the handshake.
  - SHIFT: exactly 1 cycle, shift_en=1. Tap counter k is cleared to 0. Go to ACCUM.
  - ACCUM: exactly N_HALF cycles.
    - addr_fwd=k, rom_addr=k, addr_rev=N_HALF-1-k.
    - k increments each cycle; when k=N_HALF-1, go to DRAIN.
  - DRAIN: exactly PIPE_LAT cycles, counted by the same counter, which is cleared on entry. Then go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE; a new handshake is possible on the next cycle.
- Addresses are 0 in every state except ACCUM.
- Enable pipe:
  - tap_active = (state==ACCUM); first_tap = (state==ACCUM && k==0).
  - Both are delayed PIPE_LAT cycles and drive mac_en and mac_clr.
  - mac_en is therefore high for exactly N_HALF cycles; mac_clr is high for 1 cycle.
- Timing, with handshake at cycle 0:
  - shift_en at cycle 1.
  - ACCUM over cycles 2..N_HALF+1.
  - mac_en over cycles 2+PIPE_LAT..N_HALF+1+PIPE_LAT.
  - out_valid from cycle N_HALF+2+PIPE_LAT.
  - Defaults (N_TAPS=16, PIPE_LAT=2): ACCUM 2..9, mac_en 4..11, mac_clr at 4, out_valid from 12.
- Throughput: at best one sample per N_HALF+PIPE_LAT+3 cycles (13 with defaults), when out_ready is tied high.
- Boundaries:
  - in_valid outside IDLE is ignored; the source holds the sample.
  - out_ready outside DONE is ignored.
  - out_valid held across a stall: the MAC is not enabled, so the result stays stable; addresses remain 0.
  - in_valid and out_ready both high in DONE: only the DONE->IDLE transition occurs; the sample is taken in the following IDLE cycle.
  - k never exceeds N_HALF-1; the address does not wrap inside one sequence.

Decomposition:
- Package fir_pkg:
  - state enum {IDLE, SHIFT, ACCUM, DRAIN, DONE}
  - localparam N_HALF
  - function for addr_rev
- Sub-module fir_enable_pipe: 2-bit wide, PIPE_LAT-deep shift register with asynchronous reset. Carries tap_active and first_tap to produce mac_en and mac_clr.

Test Plan:
- Reset then idle, in_valid=0 for 20 cycles -> in_ready=1, busy=0, mac_en/shift_en/out_valid never asserted.
- Single sample, defaults, out_ready=1:
  - shift_en only at cycle 1.
  - addr_fwd 0..7 and addr_rev 7..0 over cycles 2..9.
  - mac_en over cycles 4..11; mac_clr only at cycle 4.
  - out_valid at cycle 12 for 1 cycle; in_ready again at cycle 13.
- Back-to-back, in_valid held high, out_ready=1 -> handshakes exactly 13 cycles apart; mac_clr once per sample.
- Output stall: out_ready=0 for 10 cycles in DONE -> out_valid held; in_ready=0, mac_en=0, shift_en=0 throughout; release accepted in 1 cycle.
- Reset asserted at cycle 6 (mid-ACCUM) -> all outputs 0 immediately (asynchronously); in_ready=1 after release; the next sample reproduces the single-sample timing exactly.
- Corner parameters: N_TAPS=4 with PIPE_LAT=1, and N_TAPS=32 with PIPE_LAT=4 -> mac_en width equals N_HALF; out_valid occurs at cycle N_HALF+2+PIPE_LAT.
